// File: rtl/map_datapath_p.sv
// MAP core execution datapath: register file, ALU with registered flags, PC unit,
// call/data stack and heap. Optional stack guard enabled by defining MAP_DP_STACK_GUARD_EN.
module map_datapath_p #(
    parameter int          DW     = 8,
    parameter int          AW     = 8,
    parameter int          NREG   = 2,
    parameter int          SDEPTH = 16,
    parameter int          HDEPTH = 32,
    parameter int unsigned PC_RST = 0
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [$clog2(NREG)-1:0]   rd_idx,
    input  logic [$clog2(NREG)-1:0]   rs_idx,
    input  logic [DW-1:0]             imm,
    input  logic [$clog2(HDEPTH)-1:0] heap_addr,
    input  logic [2:0]                alu_op,
    input  logic [1:0]                sel_rf,
    input  logic                      rf_we,
    input  logic                      heap_we,
    input  logic [1:0]                stk_op,
    input  logic                      stk_src,
    input  logic [1:0]                sel_pc,
    input  logic                      pc_en,
    input  logic                      flag_we,
    output logic [AW-1:0]             pc_addr,
    output logic                      zero,
    output logic                      carry,
    output logic                      eq,
    output logic                      stk_full,
    output logic                      stk_empty,
    output logic                      stk_fault
);

    localparam int RW = $clog2(NREG);
    localparam int SW = $clog2(SDEPTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;

    localparam logic [1:0] STK_PUSH = 2'b01;
    localparam logic [1:0] STK_POP  = 2'b10;
    localparam logic [1:0] STK_REPL = 2'b11;

    logic [DW-1:0] rf_reg   [NREG];
    logic [DW-1:0] heap_mem [HDEPTH];
    logic [DW-1:0] stk_mem  [SDEPTH];

    logic [CW-1:0] stk_cnt_reg;
    logic [CW-1:0] stk_cnt_next;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_next;
    logic [AW-1:0] pc_inc;
    logic          zero_reg;
    logic          carry_reg;
    logic          eq_reg;
    logic          pc_upd;

    logic [DW-1:0] a_val;
    logic [DW-1:0] b_val;
    logic [DW-1:0] alu_res;
    logic          alu_carry;
    logic [DW:0]   add_sum;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] heap_rdata;
    logic [DW-1:0] stk_top;
    logic [DW-1:0] stk_wdata;
    logic          stk_wr_en;
    logic [SW-1:0] stk_wr_idx;
    logic [SW-1:0] top_idx;
    logic [SW-1:0] push_idx;
    logic [NREG-1:0] rf_wen;

    // ---------------- operand reads ----------------
    assign a_val      = rf_reg[rd_idx];
    assign b_val      = rf_reg[rs_idx];
    assign heap_rdata = heap_mem[heap_addr];

    // ---------------- ALU ----------------
    assign add_sum = {1'b0, a_val} + {1'b0, b_val};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        case (alu_op)
            OP_ADD: begin
                alu_res   = add_sum[DW-1:0];
                alu_carry = add_sum[DW];
            end
            OP_SUB: begin
                alu_res   = a_val - b_val;
                alu_carry = (a_val < b_val);
            end
            OP_AND: alu_res = a_val & b_val;
            OP_OR:  alu_res = a_val | b_val;
            OP_XOR: alu_res = a_val ^ b_val;
            OP_NOT: alu_res = ~a_val;
            OP_SHL: begin
                alu_res   = a_val << 1;
                alu_carry = a_val[DW-1];
            end
            OP_SHR: begin
                alu_res   = a_val >> 1;
                alu_carry = a_val[0];
            end
            default: begin
                alu_res   = '0;
                alu_carry = 1'b0;
            end
        endcase
    end

    // ---------------- stack ----------------
    assign stk_empty = (stk_cnt_reg == '0);
    assign stk_full  = (stk_cnt_reg == CW'(SDEPTH));
    assign top_idx   = SW'(stk_cnt_reg - CW'(1));
    assign push_idx  = SW'(stk_cnt_reg);
    assign stk_top   = stk_empty ? '0 : stk_mem[top_idx];
    assign stk_wdata = stk_src ? DW'(pc_inc) : b_val;

    // Overflowing push and underflowing pop fall through with no state change.
    always_comb begin
        stk_wr_en    = 1'b0;
        stk_wr_idx   = push_idx;
        stk_cnt_next = stk_cnt_reg;
        case (stk_op)
            STK_PUSH: begin
                if (!stk_full) begin
                    stk_wr_en    = 1'b1;
                    stk_cnt_next = stk_cnt_reg + CW'(1);
                end
            end
            STK_POP: begin
                if (!stk_empty) begin
                    stk_cnt_next = stk_cnt_reg - CW'(1);
                end
            end
            STK_REPL: begin
                stk_wr_en = 1'b1;
                if (stk_empty) begin
                    stk_cnt_next = CW'(1);
                end else begin
                    stk_wr_idx = top_idx;
                end
            end
            default: begin
                stk_wr_en = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST && stk_wr_en) begin
            stk_mem[stk_wr_idx] <= stk_wdata;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stk_cnt_reg <= '0;
        end else begin
            stk_cnt_reg <= stk_cnt_next;
        end
    end

    // ---------------- heap ----------------
    always_ff @(posedge CLK) begin
        if (!RST && heap_we) begin
            heap_mem[heap_addr] <= b_val;
        end
    end

    // ---------------- register file ----------------
    always_comb begin
        rf_wdata = alu_res;
        case (sel_rf)
            2'b00:   rf_wdata = alu_res;
            2'b01:   rf_wdata = stk_top;
            2'b10:   rf_wdata = heap_rdata;
            default: rf_wdata = imm;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_rf_wen
            assign rf_wen[gi] = rf_we && (rd_idx == RW'(gi));
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NREG; i++) begin
                rf_reg[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (rf_wen[i]) begin
                    rf_reg[i] <= rf_wdata;
                end
            end
        end
    end

    // ---------------- flags ----------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            zero_reg  <= 1'b0;
            carry_reg <= 1'b0;
            eq_reg    <= 1'b0;
        end else if (flag_we) begin
            zero_reg  <= (alu_res == '0);
            carry_reg <= alu_carry;
            eq_reg    <= (a_val == b_val);
        end
    end

    assign zero  = zero_reg;
    assign carry = carry_reg;
    assign eq    = eq_reg;

    // ---------------- PC ----------------
    assign pc_inc = pc_reg + AW'(1);

    always_comb begin
        pc_next = pc_inc;
        case (sel_pc)
            2'b00:   pc_next = pc_inc;
            2'b01:   pc_next = pc_reg + AW'(imm);
            2'b10:   pc_next = AW'(b_val);
            default: pc_next = AW'(stk_top);
        endcase
    end

`ifdef MAP_DP_STACK_GUARD_EN
    logic fault_reg;
    logic stk_bad;

    assign stk_bad = ((stk_op == STK_PUSH) && stk_full) || ((stk_op == STK_POP) && stk_empty);

    always_ff @(posedge CLK) begin
        if (RST) begin
            fault_reg <= 1'b0;
        end else if (stk_bad) begin
            fault_reg <= 1'b1;
        end
    end

    // The fault freezes the PC only from the edge after it was raised.
    assign pc_upd    = pc_en && !fault_reg;
    assign stk_fault = fault_reg;
`else
    assign pc_upd    = pc_en;
    assign stk_fault = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            pc_reg <= AW'(PC_RST);
        end else if (pc_upd) begin
            pc_reg <= pc_next;
        end
    end

    assign pc_addr = pc_reg;

endmodule
